// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution unit.
//   LANES   : fixed lane count of every vector operand
//   op_e    : 3-bit operation encoding
//   state_e : control FSM states (only used when VEC_MUL_EN is defined)
package vec_pkg;

    localparam int unsigned LANES = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_MUL = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StMulRun = 1'b1
    } state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU for every op except MUL.
// Ports:
//   a, b : lane operands (unsigned, N bits)
//   op   : operation code (vec_pkg::op_e encoding)
//   y    : lane result, wraps modulo 2^N; zero for MUL and reserved codes
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int unsigned N = 20
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            // Shifting by N or more must give zero, not a truncated shift.
            OP_SLL:  y = ({27'd0, shamt} >= N) ? '0 : (a << shamt);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_unit.sv
// 8-lane vector execution unit with register-file writeback.
// Optional feature macro: VEC_MUL_EN (sequential lane-by-lane multiplier).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake; accepted when both high at a rising edge
//   op, dst             : operation code and destination register index
//   src_a, src_b        : vector operands
//   we3, wa3, wd3       : one-cycle writeback strobe, address and data (held while we3=0)
//   busy                : multiply in progress
//   illegal             : one-cycle pulse after an illegal op is accepted
module vec_exec_unit
    import vec_pkg::*;
#(
    parameter int unsigned N = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op,
    input  logic [LANES-1:0][N-1:0] src_a,
    input  logic [LANES-1:0][N-1:0] src_b,
    input  logic [3:0]              dst,
    output logic                    we3,
    output logic [3:0]              wa3,
    output logic [LANES-1:0][N-1:0] wd3,
    output logic                    busy,
    output logic                    illegal
);

    logic                    accept;
    logic                    op_mul;
    logic                    op_illegal;
    logic                    mul_done;
    logic [3:0]              mul_wa;
    logic [LANES-1:0][N-1:0] mul_wd;
    logic [LANES-1:0][N-1:0] alu_y;

    logic                    we3_q, we3_d;
    logic                    illegal_q, illegal_d;
    logic [3:0]              wa3_q, wa3_d;
    logic [LANES-1:0][N-1:0] wd3_q, wd3_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vec_lane_alu #(
            .N (N)
        ) u_alu (
            .a  (src_a[k]),
            .b  (src_b[k]),
            .op (op),
            .y  (alu_y[k])
        );
    end

    assign accept = in_valid && in_ready;

`ifdef VEC_MUL_EN
    state_e                  state_q, state_d;
    logic [2:0]              lane_q, lane_d;
    logic [3:0]              dst_q;
    logic [LANES-1:0][N-1:0] a_q, b_q;
    logic [LANES-1:0][N-1:0] acc_q, acc_d;
    logic [N-1:0]            prod;

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q == StMulRun);
    assign op_mul     = (op == OP_MUL);
    assign op_illegal = (op == OP_ILL);

    // One shared multiplier, walked across the lanes by the lane counter.
    assign prod = a_q[lane_q] * b_q[lane_q];

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        acc_d    = acc_q;
        mul_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && op_mul) begin
                    state_d = StMulRun;
                    lane_d  = '0;
                end
            end
            StMulRun: begin
                acc_d[lane_q] = prod;
                lane_d        = lane_q + 3'd1;
                if (lane_q == 3'd7) begin
                    state_d  = StIdle;
                    mul_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mul_wa = dst_q;
    // acc_d already carries lane 7, so the full product vector lands in one edge.
    assign mul_wd = acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            lane_q  <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            if (accept && op_mul) begin
                dst_q <= dst;
                a_q   <= src_a;
                b_q   <= src_b;
            end
        end
    end
`else
    assign in_ready   = ~reset;
    assign busy       = 1'b0;
    assign op_mul     = 1'b0;
    assign op_illegal = (op == OP_ILL) || (op == OP_MUL);
    assign mul_done   = 1'b0;
    assign mul_wa     = '0;
    assign mul_wd     = '0;
`endif

    // Multiply completion and a new acceptance are mutually exclusive (in_ready=0 while busy).
    always_comb begin
        we3_d     = 1'b0;
        illegal_d = 1'b0;
        wa3_d     = wa3_q;
        wd3_d     = wd3_q;
        if (mul_done) begin
            we3_d = 1'b1;
            wa3_d = mul_wa;
            wd3_d = mul_wd;
        end else if (accept) begin
            if (op_illegal) begin
                illegal_d = 1'b1;
            end else if (!op_mul) begin
                we3_d = 1'b1;
                wa3_d = dst;
                wd3_d = alu_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q     <= 1'b0;
            illegal_q <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
        end else begin
            we3_q     <= we3_d;
            illegal_q <= illegal_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
        end
    end

    assign we3     = we3_q;
    assign illegal = illegal_q;
    assign wa3     = wa3_q;
    assign wd3     = wd3_q;

endmodule

// File: doc/vec_exec_unit.md
VEC_EXEC_UNIT -- requirements
Module: vec_exec_unit

Interface
REQ-001 SHALL have parameter N, default 20, meaning bits per lane; the lane count is fixed at 8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning an operation is presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the unit accepts an operation this cycle.
REQ-006 SHALL have port op, input, 3, the operation code (see REQ-012).
REQ-007 SHALL have port src_a, input, [7:0][N-1:0], the first vector operand (register-file read port 1).
REQ-008 SHALL have port src_b, input, [7:0][N-1:0], the second vector operand (register-file read port 2).
REQ-009 SHALL have port dst, input, 4, the destination vector register index.
REQ-010 SHALL have ports we3 (output, 1), wa3 (output, 4) and wd3 (output, [7:0][N-1:0]), the writeback to the vector register file.
REQ-011 SHALL have ports busy (output, 1, multiply in progress) and illegal (output, 1, one-cycle pulse for an illegal op).

Function
REQ-012 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL (shift a by b[4:0], result 0 if the amount is N or more), 110 MUL (low N bits), 111 reserved/illegal.
REQ-013 All arithmetic SHALL be lane-independent, unsigned, and wrap modulo 2^N; carries never cross lanes.
REQ-014 An operation SHALL be accepted when in_valid & in_ready are both high at a rising edge; the unit latches op, dst, src_a and src_b at that edge.
REQ-015 in_ready SHALL equal (state == IDLE).
REQ-016 The FSM SHALL have states IDLE and MUL_RUN; an accepted MUL moves IDLE to MUL_RUN, and every other op stays in IDLE.
REQ-017 A non-MUL legal op accepted at edge t SHALL give we3=1 with valid wa3/wd3 during cycle t+1 only (latency 1); back-to-back acceptance is permitted.
REQ-018 MUL SHALL use one shared N×N multiplier, computing lane k in MUL_RUN cycle k+1 (k=0..7) under a 3-bit lane counter.
REQ-019 When the lane counter wraps 7→0, the FSM SHALL return to IDLE and we3 SHALL be 1 for exactly the following cycle (MUL accepted at t gives writeback in cycle t+9).
REQ-020 busy SHALL equal (state == MUL_RUN).
REQ-021 we3 SHALL never be high for more than one cycle per accepted op.
REQ-022 An illegal op SHALL be accepted, SHALL give illegal=1 in cycle t+1, and SHALL leave we3=0.
REQ-023 in_valid during MUL_RUN SHALL be ignored; the source must hold the op until in_ready.
REQ-024 wd3 and wa3 SHALL hold their last values while we3=0.
REQ-025 No forwarding is needed: the register file commits on the falling edge inside the we3 cycle, so a dependent op issued the next cycle reads the new value.

Reset
REQ-026 On reset the unit SHALL go to IDLE, clear the lane counter, and set we3=0, illegal=0, busy=0, wa3=0 and wd3=0.
REQ-027 Reset during MUL_RUN SHALL abort the multiply, and no writeback SHALL ever occur for the aborted op.
REQ-028 Reset SHALL take priority over a simultaneous acceptance, which is discarded.

Configuration
REQ-029 Macro VEC_MUL_EN defined SHALL compile in the multiplier, the MUL_RUN state and the lane counter, with behaviour per REQ-018..020.
REQ-030 Without VEC_MUL_EN, opcode 110 SHALL be treated as illegal per REQ-022, busy SHALL be tied to 0, and in_ready SHALL be tied to 1 outside reset.

Structure
REQ-031 Package vec_pkg SHALL hold the LANES=8 constant, the op enum (OP_ADD..OP_ILL), and the FSM state typedef.
REQ-032 Combinational per-lane logic SHALL be sub-module vec_lane_alu (inputs a, b, op; output y; excludes MUL), instantiated 8 times.

Verification
REQ-033 N=20, ADD with src_a lanes=0xFFFFF and src_b lanes=0x00001, dst=3 -> cycle t+1: we3=1, wa3=3, all lanes 0x00000.
REQ-034 SLL with a=0x00001, b lanes {0,1,19,20,31,...} -> lanes {0x00001,0x00002,0x80000,0,0}.
REQ-035 VEC_MUL_EN, MUL with lane k: a=k+2, b=1000 -> busy for cycles t+1..t+8, in_ready=0 throughout, we3=1 only at t+9, lane k=1000·(k+2); in_valid held during busy is not accepted.
REQ-036 Reset asserted at MUL_RUN cycle 4 -> next cycle: IDLE, busy=0, and we3 stays 0 for 20 subsequent cycles.
REQ-037 Op 111, then ADD on the next cycle -> illegal=1 and we3=0 at t+1, then we3=1 at t+2; without VEC_MUL_EN, op 110 -> illegal=1.
